// File: rtl/scp_mem_pkg.sv
// Shared definitions for the SRAM access controller: bus widths, the default
// access length and the controller state encoding.
package scp_mem_pkg;

  localparam int SRAM_ADDR_W     = 17;
  localparam int SRAM_DATA_W     = 16;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } sram_state_t;

  // Expands the two byte-lane enables into a 16-bit data mask.
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Asynchronous 16-bit SRAM controller. One transfer runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> HOLD -> IDLE.
// Every pad strobe and status output is a flop, so the values driven in a
// cycle are computed from the state being entered at the edge that starts it.
//
// Request handshake: req/we/addr/byte_en/wdata are sampled only at an edge
// where the controller is IDLE (busy=0); that edge accepts the request and
// latches all of its fields. While busy=1, req is ignored completely. done is
// a single-cycle pulse in the HOLD cycle; busy falls at the following edge.
module sram_ctrl
  import scp_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [1:0]             byte_en,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  // The state register is the controller's observable status.
  sram_state_t      state_q;
  sram_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             we_q;
  logic [1:0]       be_q;

  logic                   accept;
  logic                   capture;
  logic                   we_d;
  logic [1:0]             be_d;
  logic                   active_d;
  logic [SRAM_ADDR_W-1:0] addr_d;
  logic [SRAM_DATA_W-1:0] dq_out_d;
  logic [SRAM_DATA_W-1:0] rdata_d;
  logic                   ce_n_d;
  logic                   oe_n_d;
  logic                   we_n_d;
  logic                   ub_n_d;
  logic                   lb_n_d;
  logic                   dq_oe_d;

  // Next-state logic and ACCESS-length down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ST_ACCESS: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Values the registered outputs take at the next edge. Write and read
  // strobes are gated by the latched direction, so we_n=0 and oe_n=0 can
  // never coincide, nor can dq_oe=1 with oe_n=0.
  always_comb begin
    accept   = (state_q == ST_IDLE) && req;
    capture  = (state_q == ST_ACCESS) && (cnt_q == '0) && !we_q;
    we_d     = accept ? we : we_q;
    be_d     = accept ? byte_en : be_q;
    addr_d   = accept ? addr : sram_addr;
    dq_out_d = accept ? wdata : sram_dq_out;
    active_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    ce_n_d   = (state_d == ST_IDLE);
    oe_n_d   = !(active_d && !we_d);
    we_n_d   = !((state_d == ST_ACCESS) && we_d);
    ub_n_d   = (state_d == ST_IDLE) ? 1'b1 : !be_d[1];
    lb_n_d   = (state_d == ST_IDLE) ? 1'b1 : !be_d[0];
    dq_oe_d  = (state_d != ST_IDLE) && we_d;
    rdata_d  = capture ? (sram_dq_in & lane_mask(be_q)) : rdata;
  end

  // All state and registered outputs; reset aborts any transfer silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= 2'b00;
      rdata       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      rdata       <= rdata_d;
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_HOLD);
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_ub_n   <= ub_n_d;
      sram_lb_n   <= lb_n_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a main instance (WAIT_CYCLES=2) against a
// behavioural SRAM, plus WAIT_CYCLES=1 and 15 instances reading a fixed bus.
module tb_sram_ctrl;
  import scp_mem_pkg::*;

  localparam int W = 2;

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic        req = 1'b0;
  logic        req_x = 1'b0;
  logic        we = 1'b0;
  logic [16:0] addr = '0;
  logic [1:0]  byte_en = 2'b00;
  logic [15:0] wdata = '0;

  // main instance
  logic [15:0] rdata, sram_dq_out, sram_dq_in;
  logic [16:0] sram_addr;
  logic busy, done, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  // short/long instances
  logic [15:0] alt_dq = 16'hA5C3;
  logic [15:0] rdata_1, dq_out_1, rdata_15, dq_out_15;
  logic [16:0] addr_1, addr_15;
  logic busy_1, done_1, dq_oe_1, ce_n_1, oe_n_1, we_n_1, ub_n_1, lb_n_1;
  logic busy_15, done_15, dq_oe_15, ce_n_15, oe_n_15, we_n_15, ub_n_15, lb_n_15;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_ctrl #(.WAIT_CYCLES(1)) dut_1 (
    .clk(clk), .rst(rst), .req(req_x), .we(we), .addr(addr), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata_1), .busy(busy_1), .done(done_1), .sram_addr(addr_1),
    .sram_dq_out(dq_out_1), .sram_dq_oe(dq_oe_1), .sram_dq_in(alt_dq),
    .sram_ce_n(ce_n_1), .sram_oe_n(oe_n_1), .sram_we_n(we_n_1),
    .sram_ub_n(ub_n_1), .sram_lb_n(lb_n_1)
  );

  sram_ctrl #(.WAIT_CYCLES(15)) dut_15 (
    .clk(clk), .rst(rst), .req(req_x), .we(we), .addr(addr), .byte_en(byte_en),
    .wdata(wdata), .rdata(rdata_15), .busy(busy_15), .done(done_15), .sram_addr(addr_15),
    .sram_dq_out(dq_out_15), .sram_dq_oe(dq_oe_15), .sram_dq_in(alt_dq),
    .sram_ce_n(ce_n_15), .sram_oe_n(oe_n_15), .sram_we_n(we_n_15),
    .sram_ub_n(ub_n_15), .sram_lb_n(lb_n_15)
  );

  // ---------------- SRAM model (index by low address byte) ----------------
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
    end
  end

  // strobe-exclusion watcher over all three instances
  int viol_cnt = 0;
  always @(negedge clk) begin
    if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n) ||
        (!we_n_1 && !oe_n_1) || (dq_oe_1 && !oe_n_1) ||
        (!we_n_15 && !oe_n_15) || (dq_oe_15 && !oe_n_15))
      viol_cnt = viol_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One transfer on the main instance; expected rdata is popped from exp_q.
  task automatic run_xfer(input vec_t v, input string tag);
    int done_at;
    int we_low;
    bit pin_bad;
    logic [15:0] e;
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; byte_en = v.be; wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs so only the latched copy can be correct
    req = 1'b0; we = ~v.we; addr = ~v.addr; byte_en = ~v.be; wdata = ~v.wdata;
    done_at = 0; we_low = 0; pin_bad = 1'b0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (!sram_we_n) begin
        we_low++;
        if ({sram_ub_n, sram_lb_n} !== ~v.be) pin_bad = 1'b1;
      end
      if (busy && sram_addr !== v.addr) pin_bad = 1'b1;
      if (sram_dq_oe && sram_dq_out !== v.wdata) pin_bad = 1'b1;
      if (done) done_at = n;
    end
    check($sformatf("%s done_at", tag), 32'(done_at), 32'(W + 2));
    check($sformatf("%s we_low", tag), 32'(we_low), v.we ? 32'(W) : 32'd0);
    check($sformatf("%s pins", tag), 32'(pin_bad), 32'd0);
    @(negedge clk);
    check($sformatf("%s idle", tag), {30'd0, busy, done}, 32'd0);
    e = exp_q.pop_front();
    check($sformatf("%s rdata", tag), 32'(rdata), 32'(e));
  endtask

  // One transfer on the WAIT_CYCLES=1 and 15 instances together.
  task automatic run_alt(input logic wex, input logic [1:0] bex, input logic [15:0] e, input string tag);
    int d1, d15, wl1, wl15;
    @(negedge clk);
    req_x = 1'b1; we = wex; addr = 17'h00007; byte_en = bex; wdata = 16'h3C3C;
    @(posedge clk);
    @(negedge clk);
    req_x = 1'b0;
    d1 = 0; d15 = 0; wl1 = 0; wl15 = 0;
    for (int n = 1; n <= 40 && (d1 == 0 || d15 == 0); n++) begin
      if (n > 1) @(negedge clk);
      if (!we_n_1) wl1++;
      if (!we_n_15) wl15++;
      if (done_1 && d1 == 0) d1 = n;
      if (done_15 && d15 == 0) d15 = n;
    end
    check($sformatf("%s w1 done_at", tag), 32'(d1), 32'd3);
    check($sformatf("%s w15 done_at", tag), 32'(d15), 32'd17);
    check($sformatf("%s w1 we_low", tag), 32'(wl1), wex ? 32'd1 : 32'd0);
    check($sformatf("%s w15 we_low", tag), 32'(wl15), wex ? 32'd15 : 32'd0);
    @(negedge clk);
    check($sformatf("%s alt idle", tag), {30'd0, busy_1, busy_15}, 32'd0);
    check($sformatf("%s w1 rdata", tag), 32'(rdata_1), 32'(e));
    check($sformatf("%s w15 rdata", tag), 32'(rdata_15), 32'(e));
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[15];
  logic [15:0] shadow [0:15];

  initial begin
    tbl[0]  = '{1'b1, 17'h00010, 2'b11, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 17'h00010, 2'b11, 16'h0000, 16'hBEEF};
    tbl[2]  = '{1'b1, 17'h00020, 2'b11, 16'h1234, 16'hBEEF};
    tbl[3]  = '{1'b1, 17'h00020, 2'b10, 16'h5A00, 16'hBEEF};
    tbl[4]  = '{1'b0, 17'h00020, 2'b11, 16'h0000, 16'h5A34};
    tbl[5]  = '{1'b0, 17'h00020, 2'b01, 16'h0000, 16'h0034};
    tbl[6]  = '{1'b0, 17'h00020, 2'b10, 16'h0000, 16'h5A00};
    tbl[7]  = '{1'b1, 17'h00020, 2'b00, 16'hFFFF, 16'h5A00};
    tbl[8]  = '{1'b0, 17'h00020, 2'b00, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b0, 17'h00020, 2'b11, 16'h0000, 16'h5A34};
    tbl[10] = '{1'b1, 17'h1FFFF, 2'b11, 16'hCAFE, 16'h5A34};
    tbl[11] = '{1'b0, 17'h1FFFF, 2'b11, 16'h0000, 16'hCAFE};
    tbl[12] = '{1'b1, 17'h00030, 2'b01, 16'h00AB, 16'hCAFE};
    tbl[13] = '{1'b0, 17'h00030, 2'b11, 16'h0000, 16'h00AB};
    tbl[14] = '{1'b0, 17'h00010, 2'b11, 16'h0000, 16'hBEEF};

    // reset with req high: the request must be discarded
    rst = 1'b1; req = 1'b1; req_x = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    check("reset status", {29'd0, busy, done, sram_dq_oe}, 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset addr", 32'(sram_addr), 32'd0);
    check("reset dq_out", 32'(sram_dq_out), 32'd0);
    rst = 1'b0; req = 1'b0; req_x = 1'b0;
    @(negedge clk);
    check("post-reset idle", {30'd0, busy, busy_15}, 32'd0);

    // table of single transfers
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(tbl[i].exp);
      run_xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // back-to-back: req held for 10 sampled edges -> two transfers
    begin
      int rises, r1, r2, gap, max_gap, dones;
      logic prev_busy;
      rises = 0; r1 = 0; r2 = 0; gap = 0; max_gap = 0; dones = 0; prev_busy = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 17'h00040; byte_en = 2'b11; wdata = 16'h1111;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (n == 10) req = 1'b0;
        if (busy && !prev_busy) begin
          if (rises >= 1 && gap > max_gap) max_gap = gap;
          rises++;
          if (rises == 1) r1 = n;
          if (rises == 2) r2 = n;
        end
        if (!busy) gap++; else gap = 0;
        if (done) dones++;
        prev_busy = busy;
      end
      check("b2b accepted", 32'(rises), 32'd2);
      check("b2b first edge", 32'(r1), 32'd1);
      check("b2b spacing", 32'(r2 - r1), 32'(W + 3));
      check("b2b busy gap", 32'(max_gap), 32'd1);
      check("b2b dones", 32'(dones), 32'd2);
      check("b2b mem", 32'(mem[8'h40]), 32'h1111);
      check("b2b rdata kept", 32'(rdata), 32'hBEEF);
    end

    // reset in the second ACCESS cycle of a write
    begin
      int seen;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 17'h00050; byte_en = 2'b11; wdata = 16'h7777;
      @(posedge clk);
      @(negedge clk); req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst we_n low", 32'(sram_we_n), 32'd0);
      rst = 1'b1; req = 1'b1;
      @(negedge clk);
      check("midrst strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
      check("midrst status", {29'd0, busy, done, sram_dq_oe}, 32'd0);
      check("midrst regs", {15'd0, sram_addr}, 32'd0);
      check("midrst data", {sram_dq_out, rdata}, 32'd0);
      rst = 1'b0; req = 1'b0;
      seen = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("midrst quiet", 32'(seen), 32'd0);
    end

    // short and long access builds
    run_alt(1'b0, 2'b11, 16'hA5C3, "alt rd11");
    run_alt(1'b1, 2'b11, 16'hA5C3, "alt wr");
    run_alt(1'b0, 2'b01, 16'h00C3, "alt rd01");

    // random traffic against the SRAM model, expectations from a shadow copy
    begin
      vec_t v;
      logic [15:0] last;
      logic [15:0] m;
      last = 16'h0000;
      for (int i = 0; i < 16; i++) shadow[i] = 16'h0000;
      for (int i = 0; i < 1000; i++) begin
        v.we    = 1'($urandom_range(0, 1));
        v.addr  = {9'($urandom), 4'h8, 4'($urandom_range(0, 15))};
        v.be    = 2'($urandom_range(0, 3));
        v.wdata = 16'($urandom);
        m = {{8{v.be[1]}}, {8{v.be[0]}}};
        if (v.we) begin
          shadow[v.addr[3:0]] = (shadow[v.addr[3:0]] & ~m) | (v.wdata & m);
        end else begin
          last = shadow[v.addr[3:0]] & m;
        end
        v.exp = last;
        exp_q.push_back(v.exp);
        run_xfer(v, $sformatf("rnd%0d", i));
      end
    end

    check("strobe exclusion", 32'(viol_cnt), 32'd0);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of ACCESS-state cycles per transfer, legal range 1..15.
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req  input  1  request strobe, sampled only when busy=0.
REQ-005 SHALL have we  input  1  1=write, 0=read, sampled with req.
REQ-006 SHALL have addr  input  17  word address, from the byte-to-word address stage.
REQ-007 SHALL have byte_en  input  2  lane enables, bit1=high byte, bit0=low byte.
REQ-008 SHALL have wdata  input  16  write data, already lane-aligned.
REQ-009 SHALL have rdata  output  16  registered read data.
REQ-010 SHALL have busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have done  output  1  one-cycle completion pulse.
REQ-012 SHALL have sram_addr  output  17  SRAM address pins.
REQ-013 SHALL have sram_dq_out  output  16  data driven to the pad.
REQ-014 SHALL have sram_dq_oe  output  1  pad output enable; top level forms the tristate.
REQ-015 SHALL have sram_dq_in  input  16  data sampled from the pad.
REQ-016 SHALL have sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Function
REQ-017 SHALL implement FSM IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> HOLD -> IDLE.
REQ-018 In IDLE with req=1, SHALL latch addr/we/byte_en/wdata and enter SETUP at the same edge.
REQ-019 SHALL ignore req while busy=1; dropped requests leave no trace.
REQ-020 SETUP: sram_addr driven, ce_n=0, ub_n/lb_n = ~byte_en; reads also oe_n=0; writes also dq_oe=1; we_n=1.
REQ-021 ACCESS: SETUP outputs held; writes additionally drive we_n=0; a 4-bit down-counter loaded with WAIT_CYCLES-1 on SETUP exit exits the state at 0.
REQ-022 Reads: rdata SHALL capture sram_dq_in on the final ACCESS edge; lanes with byte_en bit=0 are forced to 0x00.
REQ-023 HOLD: we_n=1, while addr, dq_oe and ce_n are unchanged for one cycle (write hold time); done=1; oe_n=1.
REQ-024 Latency: req accepted at edge k; done high during cycle k+2+WAIT_CYCLES; busy falls at the next edge.
REQ-025 rdata SHALL hold its value until the next read's capture; writes leave rdata unchanged.
REQ-026 byte_en=00 SHALL run the full sequence with ub_n=lb_n=1: no SRAM change, rdata=0x0000 on read.
REQ-027 In IDLE: ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0; sram_addr and sram_dq_out keep their last values.
REQ-028 we_n and oe_n SHALL never be low in the same cycle; dq_oe and oe_n=0 SHALL never coincide.

Reset
REQ-029 rst=1 at any edge, including mid-transfer, SHALL force IDLE, all strobes high, dq_oe=0, busy=0, done=0, rdata=0, counter=0, sram_addr=0, sram_dq_out=0.
REQ-030 A transfer interrupted by reset SHALL NOT produce done; req sampled in the reset cycle SHALL be discarded.

Structure
REQ-031 Shared package scp_mem_pkg SHALL hold the FSM state enum, SRAM_ADDR_W=17, SRAM_DATA_W=16, and the WAIT_CYCLES default.
REQ-032 SHALL be a single module with no sub-module; FSM and wait counter are inline, and all outputs are registered.

Verification
REQ-033 Write then read: write addr 0x00010 data 0xBEEF be=11, then read 0x00010 -> done at k+4 each (WAIT_CYCLES=2), rdata=0xBEEF, we_n low exactly 2 cycles.
REQ-034 Byte write: be=10 with data 0x5A00 to a word holding 0x1234 -> ub_n=0, lb_n=1 during the write; readback with be=11 returns 0x5A34.
REQ-035 Back-to-back: req held high for 10 cycles -> exactly two transfers accepted (edges 0 and 5); busy never has a gap >1 cycle; no request accepted while busy.
REQ-036 Reset mid-write: rst asserted in the second ACCESS cycle -> we_n=1, dq_oe=0 next edge, no done, memory word unchanged or only partially written (flagged, not checked).
REQ-037 WAIT_CYCLES=1 and 15 builds: done at k+3 and k+17 respectively; assertion of REQ-028 holds throughout a 1000-transfer random run against an SRAM model.
